// File: rtl/xadc_drp_arbiter.sv
// Shares the single XADC DRP between EOC-driven automatic readback and a
// software read/write channel, with round-robin arbitration and a response timeout.
module xadc_drp_arbiter #(
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned TMO_MAX = 200
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        eoc_i,
    input  logic [4:0]  channel_i,
    input  logic        sw_req_i,
    input  logic        sw_we_i,
    input  logic [6:0]  sw_addr_i,
    input  logic [15:0] sw_wdata_i,
    output logic        sw_ack_o,
    output logic        sw_err_o,
    output logic [15:0] sw_rdata_o,
    output logic        drp_den_o,
    output logic        drp_dwe_o,
    output logic [6:0]  drp_daddr_o,
    output logic [15:0] drp_di_o,
    input  logic [15:0] drp_do_i,
    input  logic        drp_drdy_i,
    output logic        smp_valid_o,
    output logic [6:0]  smp_addr_o,
    output logic [11:0] smp_data_o,
    output logic [7:0]  ovf_cnt_o
);

    localparam int unsigned OVF_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        AUTO_WAIT = 2'd1,
        SW_WAIT   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_eoc_pend;
    logic [4:0]       r_ch_q;
    logic             r_last_sw;
    logic [TMO_W-1:0] r_tmo_cnt;

    logic             w_idle_free;
    logic             w_grant_auto;
    logic             w_grant_sw;
    logic             w_tmo_hit;
    logic             w_done;

    logic             w_den_nxt;
    logic             w_dwe_nxt;
    logic [6:0]       w_daddr_nxt;
    logic [15:0]      w_di_nxt;
    logic             w_ack_nxt;
    logic             w_err_nxt;
    logic [15:0]      w_rdata_nxt;
    logic             w_smp_valid_nxt;
    logic [6:0]       w_smp_addr_nxt;
    logic [11:0]      w_smp_data_nxt;
    logic [TMO_W-1:0] w_tmo_nxt;

    // A cycle showing an ack or sample pulse is dead for arbitration (DEN spacing >= 4).
    always_comb begin
        w_idle_free  = (r_state == IDLE) && !sw_ack_o && !smp_valid_o;
        w_grant_auto = w_idle_free && r_eoc_pend && (!sw_req_i || r_last_sw);
        w_grant_sw   = w_idle_free && sw_req_i && (!r_eoc_pend || !r_last_sw);
        w_tmo_hit    = !drp_drdy_i && (r_tmo_cnt == TMO_W'(TMO_MAX));
        w_done       = drp_drdy_i || w_tmo_hit;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_auto) begin
                    w_state_nxt = AUTO_WAIT;
                end else if (w_grant_sw) begin
                    w_state_nxt = SW_WAIT;
                end
            end
            AUTO_WAIT, SW_WAIT: begin
                if (w_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_den_nxt       = 1'b0;
        w_dwe_nxt       = 1'b0;
        w_daddr_nxt     = drp_daddr_o;
        w_di_nxt        = drp_di_o;
        w_ack_nxt       = 1'b0;
        w_err_nxt       = 1'b0;
        w_rdata_nxt     = sw_rdata_o;
        w_smp_valid_nxt = 1'b0;
        w_smp_addr_nxt  = smp_addr_o;
        w_smp_data_nxt  = smp_data_o;
        w_tmo_nxt       = r_tmo_cnt;
        case (r_state)
            IDLE: begin
                if (w_grant_auto) begin
                    w_den_nxt   = 1'b1;
                    w_daddr_nxt = {2'b00, r_ch_q};
                    w_tmo_nxt   = '0;
                end else if (w_grant_sw) begin
                    w_den_nxt   = 1'b1;
                    w_dwe_nxt   = sw_we_i;
                    w_daddr_nxt = sw_addr_i;
                    w_di_nxt    = sw_wdata_i;
                    w_tmo_nxt   = '0;
                end
            end
            AUTO_WAIT: begin
                if (drp_drdy_i) begin
                    w_smp_valid_nxt = 1'b1;
                    w_smp_addr_nxt  = drp_daddr_o;
                    w_smp_data_nxt  = drp_do_i[15:4];
                end else if (!w_tmo_hit) begin
                    w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
                end
            end
            SW_WAIT: begin
                if (drp_drdy_i) begin
                    w_ack_nxt   = 1'b1;
                    w_rdata_nxt = drp_do_i;
                end else if (w_tmo_hit) begin
                    w_ack_nxt   = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_rdata_nxt = 16'h0000;
                end else begin
                    w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
                end
            end
            default: ;
        endcase
    end

    // EOC latch: a newer EOC overwrites an ungranted one and counts as lost.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_eoc_pend <= 1'b0;
            r_ch_q     <= '0;
            r_last_sw  <= 1'b0;
            ovf_cnt_o  <= '0;
        end else begin
            if (eoc_i) begin
                r_eoc_pend <= 1'b1;
                r_ch_q     <= channel_i;
                if (r_eoc_pend && !w_grant_auto && (ovf_cnt_o != {OVF_W{1'b1}})) begin
                    ovf_cnt_o <= ovf_cnt_o + OVF_W'(1);
                end
            end else if (w_grant_auto) begin
                r_eoc_pend <= 1'b0;
            end
            if (w_grant_auto || w_grant_sw) begin
                r_last_sw <= w_grant_sw;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            drp_den_o   <= 1'b0;
            drp_dwe_o   <= 1'b0;
            drp_daddr_o <= '0;
            drp_di_o    <= '0;
            sw_ack_o    <= 1'b0;
            sw_err_o    <= 1'b0;
            sw_rdata_o  <= '0;
            smp_valid_o <= 1'b0;
            smp_addr_o  <= '0;
            smp_data_o  <= '0;
            r_tmo_cnt   <= '0;
        end else begin
            drp_den_o   <= w_den_nxt;
            drp_dwe_o   <= w_dwe_nxt;
            drp_daddr_o <= w_daddr_nxt;
            drp_di_o    <= w_di_nxt;
            sw_ack_o    <= w_ack_nxt;
            sw_err_o    <= w_err_nxt;
            sw_rdata_o  <= w_rdata_nxt;
            smp_valid_o <= w_smp_valid_nxt;
            smp_addr_o  <= w_smp_addr_nxt;
            smp_data_o  <= w_smp_data_nxt;
            r_tmo_cnt   <= w_tmo_nxt;
        end
    end

endmodule
